// File: rtl/argmax_pkg.sv
// Shared types and sizing helpers for the argmax/argmin family.
package argmax_pkg;

    // Frame FSM: collecting samples, or holding a finished result.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Index width for an n-entry frame; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_NUM_INPUTS = 16;
    localparam int DEFAULT_IDX_WIDTH  = idx_width(DEFAULT_NUM_INPUTS);

endpackage

// File: rtl/serial_argmax_signed_compare_update.sv
// signed_compare_update: picks the running extreme of a signed stream.
// Macro SERIAL_ARGMAX_ARGMIN_EN flips the compare to strict less-than
// (running minimum). The strict compare keeps the earlier index on ties.
module signed_compare_update #(
    parameter int WIDTH     = 5,
    parameter int IDX_WIDTH = 4
) (
    input  logic signed [WIDTH-1:0]     candidate,
    input  logic        [IDX_WIDTH-1:0] candidate_idx,
    input  logic signed [WIDTH-1:0]     current,
    input  logic        [IDX_WIDTH-1:0] current_idx,
    input  logic                        first,
    output logic signed [WIDTH-1:0]     next_value,
    output logic        [IDX_WIDTH-1:0] next_idx
);

    logic better;

    // Take the candidate on the first beat of a frame or when it strictly wins.
    always_comb begin
`ifdef SERIAL_ARGMAX_ARGMIN_EN
        better = candidate < current;
`else
        better = candidate > current;
`endif
        if (first || better) begin
            next_value = candidate;
            next_idx   = candidate_idx;
        end else begin
            next_value = current;
            next_idx   = current_idx;
        end
    end

endmodule

// File: rtl/serial_argmax_signed.sv
// serial_argmax_signed: streaming argmax over NUM_INPUTS signed samples,
// one sample per accepted beat, one result beat per frame.
// Macro SERIAL_ARGMAX_ARGMIN_EN turns it into an argmin (same ports).
module serial_argmax_signed
    import argmax_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
    parameter int IDX_WIDTH  = idx_width(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     max,
    output logic        [IDX_WIDTH-1:0] argmax
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

    state_t                    state, state_nxt;
    logic   [IDX_WIDTH-1:0]    idx;
    logic                      accept;
    logic signed [WIDTH-1:0]   upd_value;
    logic   [IDX_WIDTH-1:0]    upd_idx;

    signed_compare_update #(
        .WIDTH     (WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_cmp (
        .candidate     (in_data),
        .candidate_idx (idx),
        .current       (max),
        .current_idx   (argmax),
        .first         (idx == '0),
        .next_value    (upd_value),
        .next_idx      (upd_idx)
    );

    // State register; reset drops any partial frame back into ACCUM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs, decoded from state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Running extreme and frame index; only accepted beats move them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            max    <= '0;
            argmax <= '0;
        end else if (accept) begin
            max    <= upd_value;
            argmax <= upd_idx;
            idx    <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

endmodule
